// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem_timer memory-mapped timer peripheral:
// register offsets, CTRL/STATUS bit positions, bus FSM state type, byte-merge helper.
package iomem_timer_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_COUNT    = 8'h04;
  localparam logic [7:0] OFF_COMPARE  = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  localparam int unsigned CTRL_ENABLE      = 32'd0;
  localparam int unsigned CTRL_IRQ_EN      = 32'd1;
  localparam int unsigned CTRL_AUTO_RELOAD = 32'd2;
  localparam int unsigned STATUS_MATCH     = 32'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wstrb);
    logic [31:0] mask;
    mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// Tick generator: pulses when its phase counter reaches the prescale value,
// so a prescale of N yields one tick every N+1 enabled cycles.
module iomem_timer_prescaler
  import iomem_timer_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [15:0] prescale,
  input  logic        clr,
  output logic        tick
);

  logic [15:0] cnt_r;
  logic        hit_s;

  // Terminal-count detect and tick qualification
  always_comb begin
    hit_s = (cnt_r == prescale);
    if (enable) begin
      tick = hit_s;
    end else begin
      tick = 1'b0;
    end
  end

  // Phase counter; holds while the timer is disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= 16'h0000;
    end else if (clr) begin
      cnt_r <= 16'h0000;
    end else if (enable) begin
      if (hit_s) begin
        cnt_r <= 16'h0000;
      end else begin
        cnt_r <= cnt_r + 16'h0001;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit timer with compare match, auto-reload and level irq.
// Optional feature: define IOMEM_TIMER_PRESCALE_EN for a programmable tick prescaler.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  state_t      state_r, state_next_s;
  logic        sel_s, accept_s, wr_s;
  logic [7:0]  off_s;
  logic        wr_ctrl_s, wr_count_s, wr_compare_s, wr_prescale_s, clr_match_s;
  logic [2:0]  ctrl_r;
  logic [31:0] count_r, compare_r;
  logic [15:0] prescale_s;
  logic        match_r;
  logic        tick_s, hit_s;
  logic [31:0] rd_mux_s, rdata_r;

  // Address decode; writes land only on the IDLE->ACK edge
  always_comb begin
    sel_s         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    accept_s      = sel_s && (state_r == ST_IDLE);
    wr_s          = accept_s && (iomem_wstrb != 4'h0);
    off_s         = iomem_addr[7:0];
    wr_ctrl_s     = wr_s && (off_s == OFF_CTRL);
    wr_count_s    = wr_s && (off_s == OFF_COUNT);
    wr_compare_s  = wr_s && (off_s == OFF_COMPARE);
    wr_prescale_s = wr_s && (off_s == OFF_PRESCALE);
    clr_match_s   = wr_s && (off_s == OFF_STATUS) && iomem_wstrb[0] && iomem_wdata[STATUS_MATCH];
    hit_s         = (count_r == compare_r);
  end

  // Bus FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus FSM next state; valid is ignored while acknowledging
  always_comb begin
    case (state_r)
      ST_IDLE: begin
        if (sel_s) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Bus FSM outputs and interrupt level
  always_comb begin
    if (state_r == ST_ACK) begin
      iomem_ready = 1'b1;
      iomem_rdata = rdata_r;
    end else begin
      iomem_ready = 1'b0;
      iomem_rdata = 32'h0000_0000;
    end
    irq = match_r && ctrl_r[CTRL_IRQ_EN];
  end

  // Read mux; unmapped offsets and reserved bits read zero
  always_comb begin
    case (off_s)
      OFF_CTRL:     rd_mux_s = {29'h0, ctrl_r};
      OFF_COUNT:    rd_mux_s = count_r;
      OFF_COMPARE:  rd_mux_s = compare_r;
      OFF_PRESCALE: rd_mux_s = {16'h0000, prescale_s};
      OFF_STATUS:   rd_mux_s = {31'h0, match_r};
      default:      rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Read data captured at accept, zero otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      rdata_r <= rd_mux_s;
    end else begin
      rdata_r <= 32'h0000_0000;
    end
  end

  // CTRL and COMPARE registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_r    <= 3'b000;
      compare_r <= 32'h0000_0000;
    end else begin
      if (wr_ctrl_s && iomem_wstrb[0]) begin
        ctrl_r <= iomem_wdata[2:0];
      end else begin
        ctrl_r <= ctrl_r;
      end
      if (wr_compare_s) begin
        compare_r <= apply_wstrb(compare_r, iomem_wdata, iomem_wstrb);
      end else begin
        compare_r <= compare_r;
      end
    end
  end

  // COUNT advance; a bus write wins over a same-cycle tick
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= 32'h0000_0000;
    end else if (wr_count_s) begin
      count_r <= apply_wstrb(count_r, iomem_wdata, iomem_wstrb);
    end else if (tick_s && hit_s && ctrl_r[CTRL_AUTO_RELOAD]) begin
      count_r <= 32'h0000_0000;
    end else if (tick_s) begin
      count_r <= count_r + 32'h0000_0001;
    end else begin
      count_r <= count_r;
    end
  end

  // Match flag; a new match wins over a same-cycle W1C
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      match_r <= 1'b0;
    end else if (tick_s && hit_s) begin
      match_r <= 1'b1;
    end else if (clr_match_s) begin
      match_r <= 1'b0;
    end else begin
      match_r <= match_r;
    end
  end

`ifdef IOMEM_TIMER_PRESCALE_EN
  logic [15:0] prescale_r;

  // PRESCALE register, bytes 0 and 1 writable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescale_r <= 16'h0000;
    end else if (wr_prescale_s) begin
      prescale_r <= {(iomem_wstrb[1] ? iomem_wdata[15:8] : prescale_r[15:8]),
                     (iomem_wstrb[0] ? iomem_wdata[7:0]  : prescale_r[7:0])};
    end else begin
      prescale_r <= prescale_r;
    end
  end

  assign prescale_s = prescale_r;
`else
  assign prescale_s = 16'h0000;
`endif

  iomem_timer_prescaler u_prescaler (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (ctrl_r[CTRL_ENABLE]),
    .prescale (prescale_s),
    .clr      (wr_prescale_s),
    .tick     (tick_s)
  );

endmodule

// File: tb/tb_iomem_timer.sv
// Self-checking bench for iomem_timer: random and directed bus traffic
// compared against a cycle-stepped behavioural model of the register map.
module tb_iomem_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_count, m_compare, m_rd;
  logic [15:0] m_prescale, m_phase;
  logic        m_match, m_ack;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic m_irq();
    return m_match && m_ctrl[1];
  endfunction

  task automatic model_reset();
    m_ctrl = 3'b0; m_count = 32'h0; m_compare = 32'h0; m_prescale = 16'h0;
    m_phase = 16'h0; m_match = 1'b0; m_ack = 1'b0; m_rd = 32'h0;
  endtask

  // Advance the model by one clock using the current bus inputs, then the DUT.
  task automatic step();
    logic acc, wr, tick, hit;
    logic [7:0]  off;
    logic [15:0] period;
    logic [31:0] rd, o_count, t32;
`ifdef IOMEM_TIMER_PRESCALE_EN
    period = m_prescale;
`else
    period = 16'h0;
`endif
    acc = !m_ack && iomem_valid && (iomem_addr[31:8] == BASE[31:8]);
    wr = acc && (iomem_wstrb != 4'h0);
    off = iomem_addr[7:0];
    rd = 32'h0;
    if (acc) begin
      case (off)
        8'h00: rd = {29'h0, m_ctrl};
        8'h04: rd = m_count;
        8'h08: rd = m_compare;
        8'h0C: rd = {16'h0, period};
        8'h10: rd = {31'h0, m_match};
        default: rd = 32'h0;
      endcase
    end
    o_count = m_count;
    tick = m_ctrl[0] && (m_phase == period);
    hit = tick && (o_count == m_compare);
    if (wr && off == 8'h0C) m_phase = 16'h0;
    else if (m_ctrl[0]) m_phase = (m_phase == period) ? 16'h0 : m_phase + 16'h1;
    if (wr && off == 8'h04) m_count = merge(o_count, iomem_wdata, iomem_wstrb);
    else if (tick) m_count = (hit && m_ctrl[2]) ? 32'h0 : o_count + 32'h1;
    if (hit) m_match = 1'b1;
    else if (wr && off == 8'h10 && iomem_wstrb[0] && iomem_wdata[0]) m_match = 1'b0;
    if (wr && off == 8'h00 && iomem_wstrb[0]) m_ctrl = iomem_wdata[2:0];
    if (wr && off == 8'h08) m_compare = merge(m_compare, iomem_wdata, iomem_wstrb);
    if (wr && off == 8'h0C) begin
      t32 = merge({16'h0, m_prescale}, iomem_wdata, {2'b00, iomem_wstrb[1:0]});
      m_prescale = t32[15:0];
    end
    m_ack = acc;
    m_rd = rd;
    @(posedge clk);
    #1;
  endtask

  // One bus access: ready before, during and after the acknowledge cycle.
  task automatic bus(input logic [31:0] addr, input logic [3:0] s, input logic [31:0] d, input bit hold,
                     output logic r0, output logic r1, output logic r2,
                     output logic [31:0] got, output logic [31:0] exp, output logic exp_ack);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = s; iomem_wdata = d;
    r0 = iomem_ready;
    step();
    r1 = iomem_ready; got = iomem_rdata; exp = m_rd; exp_ack = m_ack;
    if (!hold) iomem_valid = 1'b0;
    step();
    r2 = iomem_ready;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic a, b, c, e;
    logic [31:0] x, y;
    bus(BASE + {24'h0, off}, s, d, 1'b0, a, b, c, x, y, e);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] got, output logic [31:0] exp);
    logic a, b, c, e;
    bus(BASE + {24'h0, off}, 4'h0, 32'h0, 1'b0, a, b, c, got, exp, e);
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    iomem_valid = 1'b1; iomem_addr = BASE;
    repeat (3) @(posedge clk);
    #1;
    total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", iomem_ready); end
    total++; if (iomem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", iomem_rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq); end
    iomem_valid = 1'b0;
    model_reset();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(8'(i * 4), got, exp);
      total++; if (got !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got %h want 0", i, got); end
    end
  endtask

  task automatic test_match_irq();
    logic [31:0] got, exp;
    wr(8'h00, 4'hF, 32'h0); wr(8'h08, 4'hF, 32'd5); wr(8'h10, 4'hF, 32'h1);
    wr(8'h00, 4'hF, 32'h3);
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (irq !== m_irq()) begin bad++; $display("FAIL match_irq_cycle%0d got %b want %b", i, irq, m_irq()); end
    end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL match_irq_set got %b want 1", irq); end
    rd(8'h10, got, exp);
    total++; if (got !== 32'h1) begin bad++; $display("FAIL match_status got %h want 1", got); end
    wr(8'h10, 4'h1, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL match_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_read_hold();
    logic r0, r1, r2, ea;
    logic [31:0] got, exp, val;
    val = $urandom;
    wr(8'h00, 4'hF, 32'h0); wr(8'h04, 4'hF, val);
    bus(BASE + 32'h4, 4'h0, 32'h0, 1'b1, r0, r1, r2, got, exp, ea);
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL hold_ready_before got %b want 0", r0); end
    total++; if (r1 !== 1'b1) begin bad++; $display("FAIL hold_ready_ack got %b want 1", r1); end
    total++; if (r2 !== 1'b0) begin bad++; $display("FAIL hold_ready_after got %b want 0", r2); end
    total++; if (got !== val) begin bad++; $display("FAIL hold_rdata got %h want %h", got, val); end
  endtask

  task automatic test_wrap();
    logic [31:0] got, exp;
    wr(8'h00, 4'hF, 32'h0); wr(8'h10, 4'hF, 32'h1); wr(8'h08, 4'hF, 32'h10);
    wr(8'h04, 4'hF, 32'hFFFF_FFFF); wr(8'h00, 4'hF, 32'h1);
    rd(8'h04, got, exp);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL wrap_count got %h want 0", got); end
    rd(8'h10, got, exp);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL wrap_status got %h want 0", got); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] got, exp;
    wr(8'h00, 4'hF, 32'h0); wr(8'h10, 4'hF, 32'h1); wr(8'h08, 4'hF, 32'd3);
    wr(8'h04, 4'hF, 32'h0); wr(8'h00, 4'hF, 32'h5);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 1)) step();
      rd(8'h04, got, exp);
      total++; if (got !== exp || got > 32'd3) begin bad++; $display("FAIL reload_count%0d got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] got, exp, cmp;
    cmp = 32'h100 + 32'($urandom_range(0, 255));
    wr(8'h00, 4'hF, 32'h0); wr(8'h0C, 4'hF, 32'h0); wr(8'h08, 4'hF, cmp); wr(8'h10, 4'hF, 32'h1);
    wr(8'h00, 4'hF, 32'h1);
    wr(8'h04, 4'hF, cmp - 32'h1);
    wr(8'h10, 4'h1, 32'h1);
    rd(8'h10, got, exp);
    total++; if (got !== 32'h1) begin bad++; $display("FAIL w1c_race_status got %h want 1", got); end
  endtask

  task automatic test_wstrb_unmapped();
    logic r0, r1, r2, ea;
    logic [31:0] got, exp;
    wr(8'h00, 4'hF, 32'h0); wr(8'h08, 4'hF, 32'h0); wr(8'h08, 4'b0010, 32'hAABB_CCDD);
    rd(8'h08, got, exp);
    total++; if (got !== 32'h0000_CC00) begin bad++; $display("FAIL wstrb_compare got %h want 0000cc00", got); end
    bus(BASE + 32'h40, 4'h0, 32'h0, 1'b0, r0, r1, r2, got, exp, ea);
    total++; if (r1 !== 1'b1 || got !== 32'h0) begin bad++; $display("FAIL unmapped_read ready %b rdata %h want 1/0", r1, got); end
    bus(BASE + 32'h40, 4'hF, $urandom, 1'b0, r0, r1, r2, got, exp, ea);
    total++; if (r1 !== 1'b1 || got !== 32'h0) begin bad++; $display("FAIL unmapped_write ready %b rdata %h want 1/0", r1, got); end
    bus(BASE + 32'h104, 4'hF, $urandom, 1'b0, r0, r1, r2, got, exp, ea);
    total++; if (r1 !== 1'b0) begin bad++; $display("FAIL outside_window ready %b want 0", r1); end
    rd(8'h08, got, exp);
    total++; if (got !== 32'h0000_CC00) begin bad++; $display("FAIL unmapped_sidefx got %h want 0000cc00", got); end
  endtask

  task automatic test_prescale();
    logic [31:0] got, exp, c1, c2, want_ps, want_delta;
`ifdef IOMEM_TIMER_PRESCALE_EN
    want_ps = 32'd3; want_delta = 32'd3;
`else
    want_ps = 32'd0; want_delta = 32'd12;
`endif
    wr(8'h00, 4'hF, 32'h0); wr(8'h0C, 4'hF, 32'd3);
    rd(8'h0C, got, exp);
    total++; if (got !== want_ps) begin bad++; $display("FAIL prescale_read got %h want %h", got, want_ps); end
    wr(8'h04, 4'hF, 32'h0); wr(8'h00, 4'hF, 32'h1);
    rd(8'h04, c1, exp);
    total++; if (c1 !== exp) begin bad++; $display("FAIL prescale_count got %h want %h", c1, exp); end
    repeat (10) step();
    rd(8'h04, c2, exp);
    total++; if (c2 - c1 !== want_delta) begin bad++; $display("FAIL prescale_rate got %0d want %0d", c2 - c1, want_delta); end
    wr(8'h0C, 4'hF, 32'h0);
  endtask

  task automatic test_random();
    logic r0, r1, r2, ea;
    logic [31:0] got, exp, addr;
    logic [7:0] offs [8];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'hFC};
    for (int i = 0; i < 40; i++) begin
      addr = BASE + {24'h0, offs[$urandom_range(0, 7)]};
      if ($urandom_range(0, 7) == 0) addr = addr ^ 32'h0000_1000;
      bus(addr, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), $urandom, 1'($urandom), r0, r1, r2, got, exp, ea);
      total++; if (r1 !== ea || r2 !== 1'b0) begin bad++; $display("FAIL rand_ready%0d got %b%b want %b0", i, r1, r2, ea); end
      total++; if (got !== exp) begin bad++; $display("FAIL rand_rdata%0d got %h want %h", i, got, exp); end
      repeat ($urandom_range(0, 3)) step();
      total++; if (irq !== m_irq()) begin bad++; $display("FAIL rand_irq%0d got %b want %b", i, irq, m_irq()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    wr(8'h08, 4'hF, 32'h0); wr(8'h04, 4'hF, 32'h0); wr(8'h00, 4'hF, 32'h3);
    iomem_valid = 1'b1; iomem_addr = BASE + 32'h4; iomem_wstrb = 4'h0;
    step();
    total++; if (iomem_ready !== 1'b1) begin bad++; $display("FAIL midrst_ack got %b want 1", iomem_ready); end
    #2 resetn = 1'b0;
    #1;
    total++; if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || irq !== 1'b0)
      begin bad++; $display("FAIL midrst_drop ready %b rdata %h irq %b want 0", iomem_ready, iomem_rdata, irq); end
    iomem_valid = 1'b0;
    model_reset();
    #2 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL midrst_after%0d got %b want 0", i, iomem_ready); end
    end
    rd(8'h00, got, exp);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL midrst_ctrl got %h want 0", got); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_match_irq();
    test_read_hold();
    test_wrap();
    test_auto_reload();
    test_w1c_race();
    test_wstrb_unmapped();
    test_prescale();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
